// File: rtl/display_feeder.sv
// rtl/display_feeder.sv - value FIFO and SCROLL/NUMBER command sequencer for the text display
module display_feeder #(
    parameter int DEPTH_LOG2 = 4,
    parameter int LINES      = 45
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [31:0]           in_data,
    output logic                  in_ready,
    input  logic                  clear_req,
    output logic [3:0]            cmd,
    output logic [63:0]           data,
    input  logic                  disp_ready,
    output logic                  busy,
    output logic [DEPTH_LOG2:0]   fifo_count
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int LW    = (LINES > 1) ? $clog2(LINES) : 1;

    localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [LW-1:0]       LAST_LINE  = LW'(LINES - 1);

    localparam logic [3:0] CMD_NOP    = 4'd0;
    localparam logic [3:0] CMD_SCROLL = 4'd1;
    localparam logic [3:0] CMD_NUMBER = 4'd2;

    typedef enum logic [2:0] {
        IDLE,
        SCROLL_ISSUE,
        SCROLL_WAIT,
        NUM_ISSUE,
        NUM_WAIT,
        CLR_ISSUE,
        CLR_WAIT
    } state_t;

    state_t                  state;
    logic [31:0]             mem [DEPTH];
    logic [DEPTH_LOG2-1:0]   wr_ptr;
    logic [DEPTH_LOG2-1:0]   rd_ptr;
    logic [DEPTH_LOG2:0]     count;
    logic [31:0]             value;
    logic [LW-1:0]           line_cnt;
    logic                    clear_pending;

    logic push;
    logic pop;
    logic start_clear;
    logic clear_running;

    // A full FIFO refuses pushes even when a pop frees a slot in the same cycle
    assign in_ready      = (count != FULL_COUNT);
    assign push          = in_valid && in_ready;
    // Clear wins over queued values when the display becomes idle
    assign start_clear   = (state == IDLE) && disp_ready && clear_pending;
    assign pop           = (state == IDLE) && disp_ready && !clear_pending && (count != '0);
    assign clear_running = (state == CLR_ISSUE) || (state == CLR_WAIT);
    assign busy          = (state != IDLE) || (count != '0) || clear_pending;
    assign fifo_count    = count;

    // FIFO storage; contents need no reset because the count gates every read
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally modulo depth
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Sticky clear request; pulses during a pending or running clear are absorbed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clear_pending <= 1'b0;
        end else if (start_clear) begin
            clear_pending <= 1'b0;
        end else if (clear_req && !clear_running) begin
            clear_pending <= 1'b1;
        end
    end

    // Command sequencer; cmd/data are registered and non-zero for one cycle per command
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cmd      <= CMD_NOP;
            data     <= '0;
            value    <= '0;
            line_cnt <= '0;
        end else begin
            cmd  <= CMD_NOP;
            data <= '0;
            case (state)
                IDLE: begin
                    if (start_clear) begin
                        state    <= CLR_ISSUE;
                        line_cnt <= LAST_LINE;
                        cmd      <= CMD_SCROLL;
                    end else if (pop) begin
                        state <= SCROLL_ISSUE;
                        value <= mem[rd_ptr];
                        cmd   <= CMD_SCROLL;
                    end
                end
                SCROLL_ISSUE: begin
                    state <= SCROLL_WAIT;
                end
                SCROLL_WAIT: begin
                    if (disp_ready) begin
                        state <= NUM_ISSUE;
                        cmd   <= CMD_NUMBER;
                        data  <= {32'd0, value};
                    end
                end
                NUM_ISSUE: begin
                    state <= NUM_WAIT;
                end
                NUM_WAIT: begin
                    if (disp_ready) begin
                        state <= IDLE;
                    end
                end
                CLR_ISSUE: begin
                    state <= CLR_WAIT;
                end
                CLR_WAIT: begin
                    if (disp_ready) begin
                        if (line_cnt == '0) begin
                            state <= IDLE;
                        end else begin
                            line_cnt <= line_cnt - 1'b1;
                            state    <= CLR_ISSUE;
                            cmd      <= CMD_SCROLL;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
